// File: rtl/uart_rx.sv
// uart_rx: UART serial receiver. 8 data bits (LSB first), optional odd/even parity,
// 1 stop bit. Uses 16x (OVERSAMPLE) tick oversampling and samples each bit mid-bit.
// Received bytes are flagged with a one-cycle done_flag strobe.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   rx_in             serial line, idle high, asynchronous to clk
//   baud_rate[1:0]    00=2400 01=4800 10=9600 11=19200 (latched at start detect)
//   parity_type[1:0]  00=none 01=odd 10=even 11=none (latched at start detect)
//   data_out[7:0]     last received byte, held until the next frame completes
//   active_flag       high while a frame is being received
//   done_flag         one-cycle strobe; data_out and the error flags are valid
//   parity_error      parity mismatch on the last frame
//   frame_error       stop bit sampled low on the last frame
//
// Build option
//   UART_RX_MAJORITY_EN: each bit value is the 2-of-3 vote of the samples at the
//   decision tick and the two ticks before it. The decision tick is the same as
//   in the single-sample build.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       active_flag,
    output logic       done_flag,
    output logic       parity_error,
    output logic       frame_error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    // Clocks per tick, rounded to nearest
    localparam int unsigned DIV_2400  = (CLK_FREQ + (2400  * OVERSAMPLE) / 2) / (2400  * OVERSAMPLE);
    localparam int unsigned DIV_4800  = (CLK_FREQ + (4800  * OVERSAMPLE) / 2) / (4800  * OVERSAMPLE);
    localparam int unsigned DIV_9600  = (CLK_FREQ + (9600  * OVERSAMPLE) / 2) / (9600  * OVERSAMPLE);
    localparam int unsigned DIV_19200 = (CLK_FREQ + (19200 * OVERSAMPLE) / 2) / (19200 * OVERSAMPLE);
    localparam int unsigned CNT_W     = (DIV_2400 > 1) ? $clog2(DIV_2400) : 1;
    localparam int unsigned TICK_W    = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] START_PHASE = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] BIT_PHASE   = TICK_W'(OVERSAMPLE - 1);

    logic              rx_meta, rx_s, rx_s_d;
    logic [2:0]        state, state_d;
    logic [CNT_W-1:0]  div_cnt, div_cnt_d, div_last;
    logic [TICK_W-1:0] tick_cnt, tick_cnt_d;
    logic [2:0]        bit_cnt, bit_cnt_d;
    logic [7:0]        shift_reg, shift_d;
    logic              perr_acc, perr_acc_d;
    logic [1:0]        baud_q, baud_d;
    logic [1:0]        parity_q, par_d;
    logic [7:0]        data_d;
    logic              active_d, done_d, perr_d, ferr_d;
    logic              tick, decide, bit_v;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Tick divisor for the baud rate latched with this frame
    always_comb begin
        case (baud_q)
            2'b00:   div_last = CNT_W'(DIV_2400 - 1);
            2'b01:   div_last = CNT_W'(DIV_4800 - 1);
            2'b10:   div_last = CNT_W'(DIV_9600 - 1);
            default: div_last = CNT_W'(DIV_19200 - 1);
        endcase
    end

    assign tick   = (state != S_IDLE) && (div_cnt == div_last);
    assign decide = tick && (tick_cnt == ((state == S_START) ? START_PHASE : BIT_PHASE));

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist, hist_d;

    // The two previous tick samples vote together with the current line value
    assign bit_v = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 2'b11;
        end else begin
            hist <= hist_d;
        end
    end

    always_comb begin
        hist_d = hist;
        if (tick) begin
            hist_d = {hist[0], rx_s};
        end
    end
`else
    assign bit_v = rx_s;
`endif

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            perr_acc     <= 1'b0;
            baud_q       <= 2'b00;
            parity_q     <= 2'b00;
            data_out     <= '0;
            active_flag  <= 1'b0;
            done_flag    <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_d;
            div_cnt      <= div_cnt_d;
            tick_cnt     <= tick_cnt_d;
            bit_cnt      <= bit_cnt_d;
            shift_reg    <= shift_d;
            perr_acc     <= perr_acc_d;
            baud_q       <= baud_d;
            parity_q     <= par_d;
            data_out     <= data_d;
            active_flag  <= active_d;
            done_flag    <= done_d;
            parity_error <= perr_d;
            frame_error  <= ferr_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state;
        div_cnt_d  = div_cnt;
        tick_cnt_d = tick_cnt;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift_reg;
        perr_acc_d = perr_acc;
        baud_d     = baud_q;
        par_d      = parity_q;
        data_d     = data_out;
        active_d   = active_flag;
        done_d     = 1'b0;
        perr_d     = parity_error;
        ferr_d     = frame_error;

        if (state != S_IDLE) begin
            if (tick) begin
                div_cnt_d  = '0;
                tick_cnt_d = (tick_cnt == BIT_PHASE) ? '0 : tick_cnt + 1'b1;
            end else begin
                div_cnt_d = div_cnt + 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (rx_s_d && !rx_s) begin
                    state_d    = S_START;
                    active_d   = 1'b1;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                    perr_acc_d = 1'b0;
                    baud_d     = baud_rate;
                    par_d      = parity_type;
                end
            end
            S_START: begin
                if (decide) begin
                    if (bit_v) begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end else begin
                        // Realign so later decisions fall one full bit apart
                        state_d    = S_DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d   = {bit_v, shift_reg[7:1]};
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_d = (parity_q == 2'b01 || parity_q == 2'b10) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    perr_acc_d = (parity_q == 2'b01) ? ~(^{shift_reg, bit_v}) : (^{shift_reg, bit_v});
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    data_d   = shift_reg;
                    perr_d   = perr_acc;
                    ferr_d   = ~bit_v;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = bit_v ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                // Break condition: wait for the line to return high
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. A serial driver sends frames and
// pushes the expected byte/error flags to a queue; a monitor pops and compares
// on every done_flag strobe.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned OS       = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [1:0] baud_rate = 2'b10;
    logic [1:0] parity_type = 2'b00;
    logic [7:0] data_out;
    logic       active_flag;
    logic       done_flag;
    logic       parity_error;
    logic       frame_error;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .OVERSAMPLE(OS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .baud_rate   (baud_rate),
        .parity_type (parity_type),
        .data_out    (data_out),
        .active_flag (active_flag),
        .done_flag   (done_flag),
        .parity_error(parity_error),
        .frame_error (frame_error)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   strobes = 0;
    logic prev_done = 1'b0;

    // Bit period in clocks: rounded tick divisor times oversampling
    function automatic int unsigned bit_clks(input logic [1:0] code);
        int unsigned baud;
        case (code)
            2'b00:   baud = 2400;
            2'b01:   baud = 4800;
            2'b10:   baud = 9600;
            default: baud = 19200;
        endcase
        return ((CLK_FREQ + (baud * OS) / 2) / (baud * OS)) * OS;
    endfunction

    function automatic void expect_frame(input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        sb.push_back(e);
    endfunction

    // Scoreboard monitor: every strobe must match the oldest expected frame
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done_flag === 1'b1) begin
            strobes++;
            tests++;
            if (prev_done !== 1'b0) begin
                fails++;
                $display("FAIL done_width: done_flag high on consecutive cycles, required one-cycle strobe");
            end
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: got data=%h perr=%b ferr=%b, required no strobe",
                         data_out, parity_error, frame_error);
            end else begin
                e = sb.pop_front();
                if ({data_out, parity_error, frame_error} !== {e.data, e.perr, e.ferr}) begin
                    fails++;
                    $display("FAIL frame: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                             data_out, parity_error, frame_error, e.data, e.perr, e.ferr);
                end
            end
        end
        prev_done = done_flag;
    end

    task automatic drive(input logic v, input int unsigned n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] code,
                              input logic [1:0] pmode, input logic bad_par, input logic stop);
        int unsigned n;
        logic        p;
        n = bit_clks(code);
        drive(1'b0, n);
        for (int i = 0; i < 8; i++) drive(d[i], n);
        if (pmode == 2'b01 || pmode == 2'b10) begin
            p = (pmode == 2'b01) ? ~(^d) : ^d;
            drive(p ^ bad_par, n);
        end
        drive(stop, n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out: got %h required 00", data_out); end
        tests++; if (active_flag !== 1'b0) begin fails++; $display("FAIL reset_active: got %b required 0", active_flag); end
        tests++; if (done_flag !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", done_flag); end
        tests++; if (parity_error !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b required 0", parity_error); end
        tests++; if (frame_error !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b required 0", frame_error); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        tests++; if (active_flag !== 1'b0) begin fails++; $display("FAIL idle_active: got %b required 0", active_flag); end
    endtask

    task automatic test_no_parity;
        int s0;
        s0 = strobes;
        baud_rate = 2'b10;
        parity_type = 2'b00;
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 2'b10, 2'b00, 1'b0, 1'b1);
        drive(1'b1, bit_clks(2'b10));
        parity_type = 2'b11;
        expect_frame(8'h96, 1'b0, 1'b0);
        send_frame(8'h96, 2'b10, 2'b11, 1'b0, 1'b1);
        drive(1'b1, bit_clks(2'b10));
        tests++; if (strobes - s0 !== 2) begin fails++; $display("FAIL no_parity_strobes: got %0d required 2", strobes - s0); end
        tests++; if (sb.size() !== 0) begin fails++; $display("FAIL no_parity_pending: got %0d required 0", sb.size()); end
        tests++; if (active_flag !== 1'b0) begin fails++; $display("FAIL no_parity_active: got %b required 0", active_flag); end
    endtask

    task automatic test_odd_parity;
        int s0;
        s0 = strobes;
        parity_type = 2'b01;
        expect_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 2'b10, 2'b01, 1'b0, 1'b1);
        drive(1'b1, bit_clks(2'b10));
        expect_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 2'b10, 2'b01, 1'b1, 1'b1);
        drive(1'b1, 2 * bit_clks(2'b10));
        tests++; if (strobes - s0 !== 2) begin fails++; $display("FAIL odd_strobes: got %0d required 2", strobes - s0); end
        tests++; if (parity_error !== 1'b1) begin fails++; $display("FAIL odd_perr_held: got %b required 1", parity_error); end
        tests++; if (data_out !== 8'h3C) begin fails++; $display("FAIL odd_data_held: got %h required 3c", data_out); end
    endtask

    task automatic test_back_to_back;
        int s0;
        s0 = strobes;
        parity_type = 2'b10;
        expect_frame(8'h55, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b0, 1'b0);
        send_frame(8'h55, 2'b10, 2'b10, 1'b0, 1'b1);
        send_frame(8'hFF, 2'b10, 2'b10, 1'b0, 1'b1);
        drive(1'b1, bit_clks(2'b10));
        tests++; if (strobes - s0 !== 2) begin fails++; $display("FAIL b2b_strobes: got %0d required 2", strobes - s0); end
        tests++; if (sb.size() !== 0) begin fails++; $display("FAIL b2b_pending: got %0d required 0", sb.size()); end
        tests++; if (parity_error !== 1'b0) begin fails++; $display("FAIL b2b_perr_cleared: got %b required 0", parity_error); end
    endtask

    task automatic test_baud_rates;
        int s0;
        logic [1:0] code;
        logic [7:0] d;
        s0 = strobes;
        parity_type = 2'b00;
        for (int i = 0; i < 4; i++) begin
            code = 2'(i);
            d = 8'hC3 ^ 8'(i * 17);
            baud_rate = code;
            expect_frame(d, 1'b0, 1'b0);
            send_frame(d, code, 2'b00, 1'b0, 1'b1);
            drive(1'b1, bit_clks(code));
        end
        baud_rate = 2'b10;
        tests++; if (strobes - s0 !== 4) begin fails++; $display("FAIL baud_strobes: got %0d required 4", strobes - s0); end
        tests++; if (sb.size() !== 0) begin fails++; $display("FAIL baud_pending: got %0d required 0", sb.size()); end
    endtask

    task automatic test_frame_error;
        int s0;
        int unsigned n;
        logic [7:0] d;
        n = bit_clks(2'b10);
        d = 8'h81;
        s0 = strobes;
        parity_type = 2'b00;
        expect_frame(8'h81, 1'b0, 1'b1);
        drive(1'b0, n);
        for (int i = 0; i < 8; i++) drive(d[i], n);
        drive(1'b0, 3 * n);
        tests++; if (strobes - s0 !== 1) begin fails++; $display("FAIL ferr_strobes: got %0d required 1", strobes - s0); end
        tests++; if (frame_error !== 1'b1) begin fails++; $display("FAIL ferr_flag: got %b required 1", frame_error); end
        tests++; if (active_flag !== 1'b0) begin fails++; $display("FAIL ferr_active: got %b required 0", active_flag); end
        drive(1'b1, n);
        expect_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, 2'b10, 2'b00, 1'b0, 1'b1);
        drive(1'b1, n);
        tests++; if (strobes - s0 !== 2) begin fails++; $display("FAIL ferr_recover_strobes: got %0d required 2", strobes - s0); end
        tests++; if (frame_error !== 1'b0) begin fails++; $display("FAIL ferr_cleared: got %b required 0", frame_error); end
    endtask

    task automatic test_false_start;
        int s0;
        s0 = strobes;
        drive(1'b0, 30);
        tests++; if (active_flag !== 1'b1) begin fails++; $display("FAIL glitch_active_high: got %b required 1", active_flag); end
        drive(1'b1, 2 * bit_clks(2'b10));
        tests++; if (active_flag !== 1'b0) begin fails++; $display("FAIL glitch_active_low: got %b required 0", active_flag); end
        tests++; if (strobes - s0 !== 0) begin fails++; $display("FAIL glitch_strobes: got %0d required 0", strobes - s0); end
        tests++; if (data_out !== 8'h12) begin fails++; $display("FAIL glitch_data_held: got %h required 12", data_out); end
    endtask

    task automatic test_reset_mid_frame;
        int s0;
        int unsigned n;
        logic [7:0] d;
        n = bit_clks(2'b10);
        d = 8'h7E;
        baud_rate = 2'b10;
        parity_type = 2'b00;
        drive(1'b0, n);
        for (int i = 0; i < 4; i++) drive(d[i], n);
        drive(d[4], n / 2);
        tests++; if (active_flag !== 1'b1) begin fails++; $display("FAIL rst_mid_active_before: got %b required 1", active_flag); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if ({data_out, active_flag, done_flag, parity_error, frame_error} !== 12'h000) begin
            fails++;
            $display("FAIL rst_mid_outputs: got data=%h act=%b done=%b perr=%b ferr=%b, required all 0",
                     data_out, active_flag, done_flag, parity_error, frame_error);
        end
        s0 = strobes;
        drive(1'b1, 12 * n);
        tests++; if (strobes - s0 !== 0) begin fails++; $display("FAIL rst_mid_no_strobe: got %0d required 0", strobes - s0); end
        expect_frame(8'h7E, 1'b0, 1'b0);
        fork
            send_frame(8'h7E, 2'b10, 2'b00, 1'b0, 1'b1);
            begin
                repeat (3 * n) @(negedge clk);
                baud_rate = 2'b00;
                parity_type = 2'b01;
            end
        join
        drive(1'b1, n);
        baud_rate = 2'b10;
        parity_type = 2'b00;
        tests++; if (strobes - s0 !== 1) begin fails++; $display("FAIL rst_next_strobes: got %0d required 1", strobes - s0); end
        tests++; if (data_out !== 8'h7E) begin fails++; $display("FAIL rst_next_data: got %h required 7e", data_out); end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_odd_parity();
        test_back_to_back();
        test_baud_rates();
        test_frame_error();
        test_false_start();
        test_reset_mid_frame();
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL missing_strobes: got %0d frames outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
